// File: rtl/ahb_arbiter_slave_5_pkg.sv
// Shared types for the slave_5 arbiter: HTRANS encoding, arbiter state and
// the default channel count. Helpers classify HTRANS for hold/data-phase use.
package ahb_arbiter_slave_5_pkg;

    localparam int SLV5_CHANNEL_NUM = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // A burst is still in progress while the owner shows SEQ or BUSY.
    function automatic logic htrans_holds(input htrans_t t);
        return (t == HTRANS_SEQ) || (t == HTRANS_BUSY);
    endfunction

    // Only NONSEQ and SEQ address phases are followed by a data phase.
    function automatic logic htrans_has_data(input htrans_t t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_arbiter_slave_5_if.sv
// Bus bundle between the competing master channels and the slave_5 arbiter.
// Optional feature macro: ARB_LOCK_EN adds the per-channel hmastlock signal.
interface ahb_arbiter_slave_5_if #(
    parameter int CHANNEL_NUM = 4
);
    logic [CHANNEL_NUM-1:0]      hreq;
    logic [CHANNEL_NUM-1:0][1:0] htrans_in;
    logic                        hready;
`ifdef ARB_LOCK_EN
    logic [CHANNEL_NUM-1:0]      hmastlock;
`endif
    logic [CHANNEL_NUM-1:0]      sel_addr;
    logic [CHANNEL_NUM-1:0]      sel_data;
    logic [CHANNEL_NUM-1:0]      hgrant;

    modport slave (
        input  hreq,
        input  htrans_in,
        input  hready,
`ifdef ARB_LOCK_EN
        input  hmastlock,
`endif
        output sel_addr,
        output sel_data,
        output hgrant
    );

    modport master (
        output hreq,
        output htrans_in,
        output hready,
`ifdef ARB_LOCK_EN
        output hmastlock,
`endif
        input  sel_addr,
        input  sel_data,
        input  hgrant
    );
endinterface

// File: rtl/ahb_arbiter_slave_5_rr_picker.sv
// Combinational round-robin picker: first requester scanning from rr_ptr
// upward (mod CHANNEL_NUM), returned as one-hot, index and a valid flag.
module ahb_rr_picker #(
    parameter  int CHANNEL_NUM = 4,
    localparam int IDX_W       = $clog2(CHANNEL_NUM)
) (
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [CHANNEL_NUM-1:0] win_onehot,
    output logic [IDX_W-1:0]       win_idx,
    output logic                   win_valid
);

    int cand;

    // Scan in reverse priority so the last hit is the highest-priority requester.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = 0;
        for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr) + i) % CHANNEL_NUM;
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
        if (win_valid) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_arbiter_slave_5.sv
// Slave-side round-robin arbiter for slave_5. Produces the address-phase
// owner select (also the grant) and a one-cycle-delayed data-phase select.
// Optional feature macro: ARB_LOCK_EN (owner lock hold plus one-cycle lock tail).
module ahb_arbiter_slave_5
    import ahb_arbiter_slave_5_pkg::*;
#(
    parameter int CHANNEL_NUM = SLV5_CHANNEL_NUM
) (
    input  logic                  hclk,
    input  logic                  hreset,
    ahb_arbiter_slave_5_if.slave  bus
);

    localparam int IDX_W = $clog2(CHANNEL_NUM);

    arb_state_t             state_q, state_d;
    logic [CHANNEL_NUM-1:0] sel_addr_q, sel_addr_d;
    logic [CHANNEL_NUM-1:0] sel_data_q, sel_data_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       owner_idx_q, owner_idx_d;

    logic [CHANNEL_NUM-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

    htrans_t                owner_htrans;
    logic                   owned;
    logic                   hold_cond;

    ahb_rr_picker #(.CHANNEL_NUM(CHANNEL_NUM)) u_picker (
        .req        (bus.hreq),
        .rr_ptr     (rr_ptr_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    assign owned        = (state_q == ARB_OWN);
    assign owner_htrans = htrans_t'(bus.htrans_in[owner_idx_q]);

`ifdef ARB_LOCK_EN
    // lock_prev_q remembers the owner was locked on the previous hready edge,
    // so the first transfer after release is still held (lock tail).
    logic lock_prev_q, lock_prev_d;
    logic owner_lock;

    assign owner_lock = bus.hmastlock[owner_idx_q];
    assign hold_cond  = owned && (htrans_holds(owner_htrans) || owner_lock || lock_prev_q);

    // Track owner lock across hready edges; cleared whenever ownership is re-decided.
    always_comb begin
        lock_prev_d = lock_prev_q;
        if (bus.hready) begin
            lock_prev_d = hold_cond && owner_lock;
        end
    end

    // Lock-tail register.
    always_ff @(posedge hclk) begin
        if (hreset) lock_prev_q <= 1'b0;
        else        lock_prev_q <= lock_prev_d;
    end
`else
    assign hold_cond = owned && htrans_holds(owner_htrans);
`endif

    // Next state: data-phase pipeline plus hold-or-rearbitrate, all gated by hready.
    always_comb begin
        state_d     = state_q;
        sel_addr_d  = sel_addr_q;
        sel_data_d  = sel_data_q;
        rr_ptr_d    = rr_ptr_q;
        owner_idx_d = owner_idx_q;
        if (bus.hready) begin
            sel_data_d = (owned && htrans_has_data(owner_htrans)) ? sel_addr_q : '0;
            if (!hold_cond) begin
                if (pick_valid) begin
                    state_d     = ARB_OWN;
                    sel_addr_d  = pick_onehot;
                    owner_idx_d = pick_idx;
                    rr_ptr_d    = (pick_idx == IDX_W'(CHANNEL_NUM - 1)) ? '0
                                                                       : pick_idx + IDX_W'(1);
                end else begin
                    state_d    = ARB_IDLE;
                    sel_addr_d = '0;
                end
            end
        end
    end

    // State register with synchronous reset to "no owner, channel 0 first".
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ARB_IDLE;
            sel_addr_q  <= '0;
            sel_data_q  <= '0;
            rr_ptr_q    <= '0;
            owner_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_addr_q  <= sel_addr_d;
            sel_data_q  <= sel_data_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_idx_q <= owner_idx_d;
        end
    end

    assign bus.sel_addr = sel_addr_q;
    assign bus.sel_data = sel_data_q;
    assign bus.hgrant   = sel_addr_q;

endmodule
